// File: rtl/disp_source_sched.sv
// Rotating source selector feeding one 16-bit snapshot to the display driver.
// Optional PRIORITY_PREEMPT_EN lets a pending non-selected source take the display.
module disp_source_sched #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] src_data,
    input  logic [3:0]  src_req,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        freeze,
    output logic [15:0] data_out,
    output logic [1:0]  sel_idx,
    output logic [3:0]  sel_onehot,
    output logic [3:0]  src_ack
);

    typedef enum logic {
        S_SHOW,
        S_CAPTURE
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       onehot_q, onehot_d;
    logic [15:0]      data_q, data_d;
    logic [3:0]       ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expiry;

`ifdef PRIORITY_PREEMPT_EN
    logic             pre_hit;
    logic [1:0]       pre_idx;

    always_comb begin
        pre_hit = 1'b0;
        pre_idx = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (src_req[j] && (2'(j) != sel_q)) begin
                pre_hit = 1'b1;
                pre_idx = 2'(j);
            end
        end
    end
`endif

    assign expiry = auto_en && (cnt_q == DWELL_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ack_d   = 4'b0000;
        unique case (state_q)
            S_CAPTURE: begin
                data_d  = src_data[{sel_q, 4'b0000} +: 16];
                ack_d   = onehot_q;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (!freeze) begin
                    // Saturate so a refresh at expiry still rotates right after
                    if (auto_en && (cnt_q != DWELL_LAST)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (btn_next) begin
                        sel_d   = sel_q + 2'd1;
                        cnt_d   = '0;
                        state_d = S_CAPTURE;
                    end else if (src_req[sel_q]) begin
                        state_d = S_CAPTURE;
`ifdef PRIORITY_PREEMPT_EN
                    end else if (pre_hit) begin
                        sel_d   = pre_idx;
                        cnt_d   = '0;
                        state_d = S_CAPTURE;
`endif
                    end else if (expiry) begin
                        sel_d   = sel_q + 2'd1;
                        cnt_d   = '0;
                        state_d = S_CAPTURE;
                    end
                end
            end
            default: state_d = S_CAPTURE;
        endcase
        if (!auto_en) begin
            cnt_d = '0;
        end
        onehot_d = 4'b0001 << sel_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_CAPTURE;
            sel_q    <= 2'd0;
            onehot_q <= 4'b0001;
            data_q   <= 16'd0;
            ack_q    <= 4'b0000;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_out   = data_q;
    assign sel_idx    = sel_q;
    assign sel_onehot = onehot_q;
    assign src_ack    = ack_q;

endmodule

// File: tb/tb_disp_source_sched.sv
// Bench for disp_source_sched: vector table, ack scoreboard, rotation
// and refresh sequences with an 8-cycle dwell.
module tb_disp_source_sched;

    logic        clk;
    logic        reset_n;
    logic [15:0] src [4];
    logic [63:0] src_data;
    logic [3:0]  src_req;
    logic        btn_next;
    logic        auto_en;
    logic        freeze;
    logic [15:0] data_out;
    logic [1:0]  sel_idx;
    logic [3:0]  sel_onehot;
    logic [3:0]  src_ack;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] data;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        logic        btn;
        logic [3:0]  req;
        logic        frz;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  ack;
    } vec_t;
    vec_t vecs[16];

    assign src_data = {src[3], src[2], src[1], src[0]};

    disp_source_sched #(
        .DWELL_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .src_data(src_data),
        .src_req(src_req),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .freeze(freeze),
        .data_out(data_out),
        .sel_idx(sel_idx),
        .sel_onehot(sel_onehot),
        .src_ack(src_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        sb_t e;
        e.ack  = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic vec_t mk(input int b, input int r, input int f,
                                input int s, input int d, input int a);
        vec_t v;
        v.btn  = 1'(b);
        v.req  = 4'(r);
        v.frz  = 1'(f);
        v.sel  = 2'(s);
        v.data = 16'(d);
        v.ack  = 4'(a);
        return v;
    endfunction

    // Every ack pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (src_ack !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", int'(src_ack), 0);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                chk("sb_ack", int'(src_ack), int'(e.ack));
                chk("sb_data", int'(data_out), int'(e.data));
            end
        end
    end

    initial begin
        logic [15:0] v4 [4];
        int          k;
        reset_n  = 1'b0;
        src[0]   = 16'd1234;
        src[1]   = 16'd20;
        src[2]   = 16'd30;
        src[3]   = 16'd40;
        src_req  = 4'b0000;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        freeze   = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 1234, 0);
        vecs[1]  = mk(1, 0, 0, 1, 1234, 0);
        vecs[2]  = mk(0, 0, 0, 1, 20, 2);
        vecs[3]  = mk(0, 0, 0, 1, 20, 0);
        vecs[4]  = mk(1, 0, 0, 2, 20, 0);
        vecs[5]  = mk(1, 0, 0, 2, 30, 4);
        vecs[6]  = mk(0, 0, 0, 2, 30, 0);
        vecs[7]  = mk(0, 4, 0, 2, 30, 0);
        vecs[8]  = mk(0, 0, 0, 2, 30, 4);
        vecs[9]  = mk(1, 0, 0, 3, 30, 0);
        vecs[10] = mk(0, 0, 0, 3, 40, 8);
        vecs[11] = mk(1, 0, 0, 0, 40, 0);
        vecs[12] = mk(0, 0, 0, 0, 1234, 1);
        vecs[13] = mk(1, 0, 1, 0, 1234, 0);
        vecs[14] = mk(0, 1, 1, 0, 1234, 0);
        vecs[15] = mk(0, 0, 0, 0, 1234, 0);

        @(negedge clk);
        chk("rst_sel", int'(sel_idx), 0);
        chk("rst_onehot", int'(sel_onehot), 1);
        chk("rst_data", int'(data_out), 0);
        chk("rst_ack", int'(src_ack), 0);

        reset_n = 1'b1;
        push(4'b0001, 16'd1234);
        tick();
        chk("first_data", int'(data_out), 1234);
        chk("first_ack", int'(src_ack), 1);
        chk("first_onehot", int'(sel_onehot), 1);
        tick();
        chk("first_ack_drop", int'(src_ack), 0);

        for (int i = 0; i < 16; i++) begin
            btn_next = vecs[i].btn;
            src_req  = vecs[i].req;
            freeze   = vecs[i].frz;
            if (vecs[i].ack != 4'b0000) push(vecs[i].ack, vecs[i].data);
            tick();
            chk($sformatf("vec%0d_sel", i), int'(sel_idx), int'(vecs[i].sel));
            chk($sformatf("vec%0d_onehot", i), int'(sel_onehot),
                int'(4'b0001 << vecs[i].sel));
            chk($sformatf("vec%0d_data", i), int'(data_out), int'(vecs[i].data));
            chk($sformatf("vec%0d_ack", i), int'(src_ack), int'(vecs[i].ack));
        end
        btn_next = 1'b0;
        src_req  = 4'b0000;
        freeze   = 1'b0;

        src[0]  = 16'd555;
        src_req = 4'b0001;
        freeze  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            btn_next = 1'((i % 2) == 0);
            tick();
            chk("frz_sel", int'(sel_idx), 0);
            chk("frz_data", int'(data_out), 1234);
            chk("frz_ack", int'(src_ack), 0);
        end
        btn_next = 1'b0;
        freeze   = 1'b0;
        push(4'b0001, 16'd555);
        tick();
        src_req = 4'b0000;
        tick();
        chk("frz_served_data", int'(data_out), 555);
        chk("frz_served_ack", int'(src_ack), 1);
        tick();

        src_req = 4'b1010;
`ifdef PRIORITY_PREEMPT_EN
        push(4'b0010, 16'd20);
`endif
        tick();
`ifdef PRIORITY_PREEMPT_EN
        chk("pre_sel", int'(sel_idx), 1);
`else
        chk("pre_sel", int'(sel_idx), 0);
`endif
        src_req = 4'b0000;
        tick();
`ifdef PRIORITY_PREEMPT_EN
        chk("pre_data", int'(data_out), 20);
`else
        chk("pre_data", int'(data_out), 555);
`endif
        tick();

        btn_next = 1'b1;
`ifdef PRIORITY_PREEMPT_EN
        push(4'b0100, 16'd30);
`else
        push(4'b0010, 16'd20);
`endif
        tick();
        btn_next = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_sel", int'(sel_idx), 0);
        chk("midrst_onehot", int'(sel_onehot), 1);
        chk("midrst_data", int'(data_out), 0);
        chk("midrst_ack", int'(src_ack), 0);

        v4[0] = 16'd10;
        v4[1] = 16'd20;
        v4[2] = 16'd30;
        v4[3] = 16'd40;
        for (int i = 0; i < 4; i++) src[i] = v4[i];
        auto_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        // Period is 9 edges: 8 shown + 1 capture; btn at edge 54 meets expiry
        for (int e = 1; e <= 58; e++) begin
            k = ((e - 1) / 9) % 4;
            if (((e - 1) % 9) == 0) push(4'b0001 << k, v4[k]);
            btn_next = 1'(e == 54);
            tick();
            chk($sformatf("auto_sel_e%0d", e), int'(sel_idx), (e / 9) % 4);
            chk($sformatf("auto_data_e%0d", e), int'(data_out), int'(v4[k]));
        end
        btn_next = 1'b0;

        src[2]  = 16'd99;
        src_req = 4'b0100;
        push(4'b0100, 16'd99);
        tick();
        chk("refr_sel", int'(sel_idx), 2);
        src_req = 4'b0000;
        tick();
        chk("refr_data", int'(data_out), 99);
        tick();
        tick();
        tick();
        chk("refr_not_yet", int'(sel_idx), 2);
        push(4'b1000, 16'd40);
        tick();
        chk("refr_rotate_sel", int'(sel_idx), 3);
        tick();
        chk("refr_rotate_data", int'(data_out), 40);
        tick();
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
